// File: rtl/irq_onehot_arbiter.sv
// irq_onehot_arbiter: captures request rising edges and issues one-hot grants under valid/ack.
// Define IRQ_ARB_FIXED_PRIO_EN for fixed priority (highest index wins); default is round-robin.
module irq_onehot_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq,
    input  logic       en,
    input  logic       ack,
    output logic [7:0] grant,
    output logic       valid,
    output logic [7:0] pending
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    logic [0:0] state;
    logic [7:0] irq_q, sel, clr;
    assign valid = (state == GRANT);
    assign clr = (valid && ack) ? grant : 8'h00;
`ifdef IRQ_ARB_FIXED_PRIO_EN
    always_comb begin
        sel = 8'h00;
        for (int i = 0; i < 8; i++)
            if (pending[i]) sel = 8'b1 << i;
    end
`else
    logic [2:0] ptr, idx, gidx;
    // search starts just after the last acked index and wraps modulo 8
    always_comb begin
        sel = 8'h00;
        idx = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr + 3'(i);
            if (sel == 8'h00 && pending[idx]) sel[idx] = 1'b1;
        end
    end
    always_comb begin
        gidx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (grant[i]) gidx = 3'(i);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 3'd7;
        else if (valid && ack)
            ptr <= gidx;
    end
`endif
    // a rise on the bit being acked re-sets it in the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= 8'h00;
            pending <= 8'h00;
            irq_q   <= 8'h00;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~clr) | (irq & ~irq_q);
            if (state == IDLE && en && |pending) begin
                state <= GRANT;
                grant <= sel;
            end else if (state == GRANT && ack) begin
                state <= IDLE;
                grant <= 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_irq_onehot_arbiter.sv
// tb_irq_onehot_arbiter: directed scoreboard bench for irq_onehot_arbiter.
module tb_irq_onehot_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq = 8'h00;
    logic       en = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] grant, pending;
    logic       valid;
    logic       valid_q = 1'b0;
    logic       sb_on = 1'b1;
    logic [7:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    irq_onehot_arbiter dut (
        .clk(clk), .rst(rst), .irq(irq), .en(en), .ack(ack),
        .grant(grant), .valid(valid), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq = 8'h00;
        en = 1'b0;
        ack = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic serve();
        for (int i = 0; i < 20 && !valid; i++) tick();
        chk("grant_wait", 8'(valid), 8'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_drops_valid", 8'(valid), 8'd0);
    endtask

    // monitor: invariants every cycle, scoreboard pop on each newly presented grant
    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot0", 8'($onehot0(grant)), 8'd1);
            chk("valid_vs_grant", 8'(valid), 8'(|grant));
            if (valid) chk("grant_in_pending", grant & ~pending, 8'h00);
            if (valid && !valid_q && sb_on) begin
                if (exp_q.size() == 0) chk("grant_unexpected", grant, 8'h00);
                else chk("grant_order", grant, exp_q.pop_front());
            end
        end
        valid_q = rst ? 1'b0 : valid;
    end

    initial begin
        tick(2);
        chk("rst_pending", pending, 8'h00);
        chk("rst_grant", grant, 8'h00);
        chk("rst_valid", 8'(valid), 8'd0);
        rst = 1'b0;
        // single request
        en = 1'b1;
        irq = 8'h04;
        exp_q.push_back(8'h04);
        tick();
        chk("single_pending", pending, 8'h04);
        chk("single_not_yet", 8'(valid), 8'd0);
        tick();
        chk("single_grant", grant, 8'h04);
        ack = 1'b1;
        irq = 8'h00;
        tick();
        ack = 1'b0;
        chk("single_cleared", pending, 8'h00);
        chk("single_idle", 8'(valid), 8'd0);
        // round-robin fairness with wrap
        do_reset();
        en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            irq = 8'h81;
`ifdef IRQ_ARB_FIXED_PRIO_EN
            exp_q.push_back(8'h80);
            exp_q.push_back(8'h01);
`else
            exp_q.push_back(8'h01);
            exp_q.push_back(8'h80);
`endif
            tick();
            irq = 8'h00;
            serve();
            serve();
        end
        // hold stability
        do_reset();
        en = 1'b1;
        irq = 8'h10;
        exp_q.push_back(8'h10);
        tick(2);
        chk("hold_valid_rise", 8'(valid), 8'd1);
        irq = 8'h12;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_grant", grant, 8'h10);
            chk("hold_valid", 8'(valid), 8'd1);
        end
        chk("hold_pending", pending, 8'h12);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("hold_ack_valid", 8'(valid), 8'd0);
        chk("hold_ack_pending", pending, 8'h02);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_low_no_grant", 8'(valid), 8'd0);
        end
        exp_q.push_back(8'h02);
        en = 1'b1;
        tick();
        chk("en_high_grant", grant, 8'h02);
        serve();
        // set-wins collision
        irq = 8'h00;
        tick();
        irq = 8'h02;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        tick(2);
        chk("coll_grant", grant, 8'h02);
        irq = 8'h00;
        tick();
        irq = 8'h02;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("coll_pending", pending, 8'h02);
        chk("coll_valid_low", 8'(valid), 8'd0);
        tick();
        chk("coll_reissue", grant, 8'h02);
        serve();
        irq = 8'h00;
        // asynchronous reset mid-handshake
        do_reset();
        en = 1'b1;
        irq = 8'hF0;
        exp_q.push_back(8'h10);
        tick(3);
        chk("mid_pending", pending, 8'hF0);
        chk("mid_grant", grant, 8'h10);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 8'(valid), 8'd0);
        chk("async_grant", grant, 8'h00);
        chk("async_pending", pending, 8'h00);
        tick(2);
        rst = 1'b0;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h80);
        for (int i = 0; i < 4; i++) serve();
        chk("sb_empty_directed", 8'(exp_q.size()), 8'd0);
        // random invariant soak
        do_reset();
        sb_on = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            irq = 8'($urandom);
            en = 1'($urandom);
            ack = 1'($urandom);
            tick();
        end
        ack = 1'b0;
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/irq_onehot_arbiter.md
# irq_onehot_arbiter

Captures rising edges on eight request lines into a pending register and arbitrates among the pending requests. It issues exactly one request at a time as a one-hot grant vector, held under a valid/ack handshake. The grant vector feeds the 8-to-3 encoder stage directly: that stage always sees either all-zeros or a legal one-hot code. It never sees a multi-hot pattern.

## Interface
- N, 8, number of request lines; fixed at 8 to match the downstream encoder width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- irq  in  N  request lines, synchronous to clk; a 0→1 transition is one request
- en  in  1  grant enable; low blocks issuing new grants, edges still captured
- ack  in  1  consumer accepts current grant; meaningful only while valid=1
- grant  out  N  one-hot granted request; all-zeros when valid=0
- valid  out  1  grant is presented and stable
- pending  out  N  captured, not-yet-acked requests

## Operation
- Edge capture: registered copy irq_q; rise = irq & ~irq_q; pending |= rise every cycle.
- Clear: on the edge where valid&&ack, the granted bit is cleared from pending.
- If a new rise hits that same bit in the same cycle, set wins and the bit stays pending.
- FSM, two states:
  - IDLE: valid=0, grant=0. If en && |pending → select one bit, load grant, go to GRANT.
  - GRANT: valid=1; grant is held constant, regardless of en, irq or pending changes. On ack → clear bit, update pointer, go to IDLE.
- Round-robin selection: ptr holds the index of the last acked grant. Search order is ptr+1, ptr+2, … wrapping modulo 8; the first pending bit wins. ptr is 3 bits and wraps 7→0.
- en deasserted in GRANT: no effect; the grant stays until ack and is never withdrawn.
- ack while valid=0: ignored, no state change.
- grant is always zero or exactly one-hot, and grant ⊆ pending while valid=1.
- Reset (asynchronous, any time including mid-handshake): state=IDLE, valid=0, grant=0, pending=0, irq_q=0, ptr=7 so the first search starts at bit 0.
- irq held high across reset release counts as a rising edge on the first clock.

## Timing
- irq bit rises before edge k → pending bit set after edge k → grant/valid asserted after edge k+1. Latency is 2 cycles with the block idle and en=1.
- Outputs are registered; there is no combinational path from irq or ack to grant/valid.
- Ack at edge m → valid low after m. The next grant is valid after m+1 at the earliest, so there is always exactly one idle cycle between grants.
- Maximum throughput: one grant per 2 cycles when ack is returned the cycle valid rises.
- pending reflects sets and clears of edge k immediately after edge k.

## Configuration
- IRQ_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; the highest-index pending bit always wins. ptr is not implemented and is not updated.
  - Undefined (default): round-robin as above.
  - Edge capture, handshake, timing and reset behaviour are identical in both builds.

## Test plan
- Single request: reset, en=1, irq=8'h04 from cycle 2. Required: pending=8'h04 after edge 2; grant=8'h04, valid=1 after edge 3. Ack one cycle → pending=0, valid=0.
- Round-robin fairness: irq=8'h81 rising together, ack each grant immediately. Required order: grant 8'h01, then 8'h80. Re-pulse both → 8'h01, then 8'h80 again (ptr wraps 7→0). Under IRQ_ARB_FIXED_PRIO_EN the order is 8'h80, then 8'h01.
- Hold stability: grant=8'h10 pending, ack low 5 cycles. During that window raise irq[1] and drop en. Required: grant stays 8'h10, valid=1, pending=8'h12. After ack with en=0: valid=0, and no new grant until en=1.
- Set-wins collision: while grant=8'h02, pulse irq[1] low→high so its rise coincides with the ack edge. Required: pending[1] remains 1, and grant 8'h02 is re-issued 2 cycles later.
- Reset mid-handshake: valid=1, pending=8'hF0; assert rst between clock edges. Required: valid, grant and pending go to 0 immediately without waiting for clk. After release with irq=8'hF0 held, the first grant is 8'h10 (search starts at bit 0).
- One-hot invariant: random irq/ack/en for 10k cycles. Required: grant is always in {0, one-hot}, valid==|grant, and grant ⊆ pending whenever valid=1.
